// File: rtl/sram_port_ctrl_if.sv
// Core-side request/response channels of sram_port_ctrl: write, read and read-response
// valid/ready handshakes plus the outstanding-read indicator.
interface sram_port_ctrl_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_WMASKS-1:0] wr_mask;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  busy;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
      input  wr_ready, rd_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
      output wr_ready, rd_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/sram_port_ctrl.sv
// Initiator for a dual-port SRAM macro (port 0 write-only, port 1 read-only): registered
// macro pins, 2-stage read pipeline, credit-limited response FIFO, same-address hazard stall.
module sram_port_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   sram_port_ctrl_if.slave       bus,
   output logic                  o_sram_csb0,
   output logic [NUM_WMASKS-1:0] o_sram_wmask0,
   output logic [ADDR_WIDTH-1:0] o_sram_addr0,
   output logic [DATA_WIDTH-1:0] o_sram_din0,
   output logic                  o_sram_csb1,
   output logic [ADDR_WIDTH-1:0] o_sram_addr1,
   input  logic [DATA_WIDTH-1:0] i_sram_dout1
);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1);
      end
   endfunction

   logic                  r_csb0;
   logic [NUM_WMASKS-1:0] r_wmask0;
   logic [ADDR_WIDTH-1:0] r_addr0;
   logic [DATA_WIDTH-1:0] r_din0;
   logic                  r_csb1;
   logic [ADDR_WIDTH-1:0] r_addr1;
   logic                  r_s2_vld;
   logic [CNT_W-1:0]      r_outstanding;
   logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_fifo_cnt;

   logic w_mask_nz, w_hazard, w_wr_fire, w_rd_fire, w_pop, w_rsp_valid;

   // The write wins a same-address collision; the read retries next cycle and sees new data.
   assign w_mask_nz   = (bus.wr_mask != {NUM_WMASKS{1'b0}});
   assign w_hazard    = bus.wr_valid & w_mask_nz & (bus.wr_addr == bus.rd_addr);
   assign w_rsp_valid = (r_fifo_cnt != {CNT_W{1'b0}});
   assign w_wr_fire   = bus.wr_valid & ~i_rst;
   assign w_rd_fire   = bus.rd_valid & bus.rd_ready;
   assign w_pop       = w_rsp_valid & bus.rsp_ready;

   assign bus.wr_ready  = ~i_rst;
   assign bus.rd_ready  = ~i_rst & (r_outstanding < CNT_W'(RSP_DEPTH)) & ~w_hazard;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_data  = r_mem[r_rd_ptr];
   assign bus.busy      = (r_outstanding != {CNT_W{1'b0}});

   assign o_sram_csb0   = r_csb0;
   assign o_sram_wmask0 = r_wmask0;
   assign o_sram_addr0  = r_addr0;
   assign o_sram_din0   = r_din0;
   assign o_sram_csb1   = r_csb1;
   assign o_sram_addr1  = r_addr1;

   // Port-0 pins: zero-mask writes are consumed without selecting the macro.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_csb0   <= 1'b1;
         r_wmask0 <= {NUM_WMASKS{1'b0}};
         r_addr0  <= {ADDR_WIDTH{1'b0}};
         r_din0   <= {DATA_WIDTH{1'b0}};
      end else if (w_wr_fire & w_mask_nz) begin
         r_csb0   <= 1'b0;
         r_wmask0 <= bus.wr_mask;
         r_addr0  <= bus.wr_addr;
         r_din0   <= bus.wr_data;
      end else begin
         r_csb0   <= 1'b1;
      end
   end

   // Read pipeline: S1 is the port-1 pin register, S2 retires when dout1 is valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_csb1   <= 1'b1;
         r_addr1  <= {ADDR_WIDTH{1'b0}};
         r_s2_vld <= 1'b0;
      end else begin
         r_s2_vld <= ~r_csb1;
         if (w_rd_fire) begin
            r_csb1  <= 1'b0;
            r_addr1 <= bus.rd_addr;
         end else begin
            r_csb1  <= 1'b1;
         end
      end
   end

   // Read credits: counts reads accepted but not yet popped from the response FIFO.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_outstanding <= {CNT_W{1'b0}};
      end else begin
         case ({w_rd_fire, w_pop})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Response FIFO; credits guarantee a free slot whenever S2 retires.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            r_mem[i] <= {DATA_WIDTH{1'b0}};
         end
         r_wr_ptr   <= {PTR_W{1'b0}};
         r_rd_ptr   <= {PTR_W{1'b0}};
         r_fifo_cnt <= {CNT_W{1'b0}};
      end else begin
         if (r_s2_vld) begin
            r_mem[r_wr_ptr] <= i_sram_dout1;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({r_s2_vld, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural SRAM macro, transaction-level reference memory and
// expected-response queue, directed test-plan steps followed by a randomized phase.
module tb_sram_port_ctrl;
   logic        clk, rst, clr;
   logic        sram_csb0, sram_csb1;
   logic [3:0]  sram_wmask0;
   logic [10:0] sram_addr0, sram_addr1;
   logic [31:0] sram_din0, sram_dout1;

   sram_port_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .NUM_WMASKS(4)) bus_if ();

   sram_port_ctrl dut (
      .i_clk(clk), .i_rst(rst), .bus(bus_if),
      .o_sram_csb0(sram_csb0), .o_sram_wmask0(sram_wmask0), .o_sram_addr0(sram_addr0),
      .o_sram_din0(sram_din0), .o_sram_csb1(sram_csb1), .o_sram_addr1(sram_addr1),
      .i_sram_dout1(sram_dout1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Macro model: pins sampled on posedge, array accessed on negedge.
   logic        s_csb0, s_csb1;
   logic [3:0]  s_wmask0;
   logic [10:0] s_addr0, s_addr1;
   logic [31:0] s_din0;
   logic [31:0] mem [0:2047];

   always @(posedge clk) begin
      s_csb0   <= sram_csb0;
      s_wmask0 <= sram_wmask0;
      s_addr0  <= sram_addr0;
      s_din0   <= sram_din0;
      s_csb1   <= sram_csb1;
      s_addr1  <= sram_addr1;
   end

   always @(negedge clk) begin
      if (clr) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
      end else begin
         if (!s_csb0) begin
            for (int b = 0; b < 4; b++)
               if (s_wmask0[b]) mem[s_addr0][8*b +: 8] <= s_din0[8*b +: 8];
         end
         if (!s_csb1) sram_dout1 <= mem[s_addr1];
      end
   end

   // Reference model
   typedef struct packed { logic [31:0] d; int c; } rsp_t;
   logic [31:0] ref_mem [int];
   rsp_t        q [$];
   int          out, cyc, n_tests, n_fail;
   bit          p_wr, p_rd, m_rd_fire;
   logic [10:0] p_addr0, p_addr1;
   logic [31:0] p_din0, last_pop;
   logic [3:0]  p_mask0;

   function automatic logic [31:0] ref_rd(input logic [10:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic        haz, erdy, evld, rf, pf;
      logic [31:0] w;
      #1;
      haz  = bus_if.wr_valid && (bus_if.wr_mask != 4'h0) && (bus_if.wr_addr == bus_if.rd_addr);
      erdy = (out < 4) && !haz;
      evld = (q.size() > 0) && (q[0].c <= cyc);
      chk("wr_ready", 64'(bus_if.wr_ready), 64'(1'b1));
      chk("rd_ready", 64'(bus_if.rd_ready), 64'(erdy));
      chk("busy", 64'(bus_if.busy), 64'(out != 0));
      chk("rsp_valid", 64'(bus_if.rsp_valid), 64'(evld));
      if (evld) chk("rsp_data", 64'(bus_if.rsp_data), 64'(q[0].d));
      chk("csb0", 64'(sram_csb0), 64'(!p_wr));
      if (p_wr) begin
         chk("addr0", 64'(sram_addr0), 64'(p_addr0));
         chk("din0", 64'(sram_din0), 64'(p_din0));
         chk("wmask0", 64'(sram_wmask0), 64'(p_mask0));
      end
      chk("csb1", 64'(sram_csb1), 64'(!p_rd));
      if (p_rd) chk("addr1", 64'(sram_addr1), 64'(p_addr1));
      rf = bus_if.rd_valid && erdy;
      pf = evld && bus_if.rsp_ready;
      if (pf) begin
         last_pop = q[0].d;
         void'(q.pop_front());
         out--;
      end
      p_wr = bus_if.wr_valid && (bus_if.wr_mask != 4'h0);
      if (p_wr) begin
         w = ref_rd(bus_if.wr_addr);
         for (int b = 0; b < 4; b++)
            if (bus_if.wr_mask[b]) w[8*b +: 8] = bus_if.wr_data[8*b +: 8];
         ref_mem[int'(bus_if.wr_addr)] = w;
         p_addr0 = bus_if.wr_addr;
         p_din0  = bus_if.wr_data;
         p_mask0 = bus_if.wr_mask;
      end
      if (rf) begin
         q.push_back('{d: ref_rd(bus_if.rd_addr), c: cyc + 3});
         out++;
      end
      p_rd = rf;
      p_addr1 = bus_if.rd_addr;
      m_rd_fire = rf;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus_if.wr_valid = 1'b0; bus_if.rd_valid = 1'b0; bus_if.rsp_ready = 1'b0;
      repeat (n) begin
         #1;
         chk("rst_wr_ready", 64'(bus_if.wr_ready), 64'(1'b0));
         chk("rst_rd_ready", 64'(bus_if.rd_ready), 64'(1'b0));
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      rst = 1'b0;
      q.delete();
      out = 0; p_wr = 1'b0; p_rd = 1'b0; m_rd_fire = 1'b0;
      #1;
      chk("rst_csb0", 64'(sram_csb0), 64'(1'b1));
      chk("rst_csb1", 64'(sram_csb1), 64'(1'b1));
      chk("rst_addr0", 64'(sram_addr0), 64'(0));
      chk("rst_addr1", 64'(sram_addr1), 64'(0));
      chk("rst_din0", 64'(sram_din0), 64'(0));
      chk("rst_wmask0", 64'(sram_wmask0), 64'(0));
      chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'(1'b0));
      chk("rst_rsp_data", 64'(bus_if.rsp_data), 64'(0));
      chk("rst_busy", 64'(bus_if.busy), 64'(1'b0));
      chk("post_rst_rd_ready", 64'(bus_if.rd_ready), 64'(1'b1));
   endtask

   task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
      bus_if.wr_valid = 1'b1; bus_if.wr_addr = a; bus_if.wr_data = d; bus_if.wr_mask = m;
   endtask

   task automatic drain();
      bus_if.wr_valid = 1'b0; bus_if.rd_valid = 1'b0; bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 20 && (q.size() > 0); i++) cycle();
      chk("drain_empty", 64'(q.size()), 64'(0));
      cycle();
   endtask

   initial begin
      int a, acc, n;
      n_tests = 0; n_fail = 0; cyc = 0; out = 0;
      p_wr = 1'b0; p_rd = 1'b0; m_rd_fire = 1'b0; last_pop = 32'h0;
      p_addr0 = 11'h0; p_addr1 = 11'h0; p_din0 = 32'h0; p_mask0 = 4'h0;
      clr = 1'b1; rst = 1'b1;
      bus_if.wr_valid = 1'b0; bus_if.wr_addr = 11'h0; bus_if.wr_data = 32'h0; bus_if.wr_mask = 4'h0;
      bus_if.rd_valid = 1'b0; bus_if.rd_addr = 11'h0; bus_if.rsp_ready = 1'b0;
      do_reset(2);
      clr = 1'b0;

      // Write then read
      wr(11'h005, 32'hDEADBEEF, 4'hF); bus_if.rsp_ready = 1'b1; cycle();
      bus_if.wr_valid = 1'b0; bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'h005; cycle();
      drain();
      chk("wr_rd_data", 64'(last_pop), 64'(32'hDEADBEEF));

      // Byte mask, then a zero-mask write that must not touch the array
      wr(11'h005, 32'h11223344, 4'hF); cycle();
      wr(11'h005, 32'hAABBCCDD, 4'b0101); cycle();
      wr(11'h005, 32'hFFFFFFFF, 4'h0); cycle();
      bus_if.wr_valid = 1'b0; cycle();
      bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'h005; cycle();
      drain();
      chk("mask_data", 64'(last_pop), 64'(32'h11BB33DD));

      // Same-address hazard
      wr(11'h07F, 32'h0000CAFE, 4'hF); bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'h07F; cycle();
      chk("haz_stall", 64'(m_rd_fire), 64'(1'b0));
      bus_if.wr_valid = 1'b0; cycle();
      chk("haz_accept", 64'(m_rd_fire), 64'(1'b1));
      drain();
      chk("haz_data", 64'(last_pop), 64'(32'h0000CAFE));

      // Backpressure
      for (int i = 0; i < 6; i++) begin wr(11'(i), $urandom, 4'hF); cycle(); end
      bus_if.wr_valid = 1'b0; bus_if.rsp_ready = 1'b0;
      a = 0; acc = 0;
      repeat (8) begin
         bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'(a); cycle();
         if (m_rd_fire) begin a++; acc++; end
      end
      chk("bp_accepts", 64'(acc), 64'(4));
      chk("bp_busy", 64'(bus_if.busy), 64'(1'b1));
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 20 && a < 6; i++) begin
         bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'(a); cycle();
         if (m_rd_fire) a++;
      end
      chk("bp_all_issued", 64'(a), 64'(6));
      drain();

      // Streaming
      n = 0;
      for (int i = 0; i < 16; i++) begin
         bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'(12'h010 + i); cycle();
         if (m_rd_fire) n++;
      end
      chk("stream_accepts", 64'(n), 64'(16));
      drain();

      // Randomized traffic on a small address window
      for (int i = 0; i < 300; i++) begin
         if (!(bus_if.rd_valid && !m_rd_fire)) begin
            bus_if.rd_valid = 1'($urandom_range(0, 1));
            bus_if.rd_addr  = 11'($urandom_range(0, 7));
         end
         bus_if.wr_valid  = 1'($urandom_range(0, 1));
         bus_if.wr_addr   = 11'($urandom_range(0, 7));
         bus_if.wr_data   = $urandom;
         bus_if.wr_mask   = 4'($urandom_range(0, 15));
         bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      // Reset with reads in flight and a write one edge before reset
      bus_if.rsp_ready = 1'b0;
      bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'h001; cycle();
      bus_if.rd_addr = 11'h002; wr(11'h0A0, 32'h5A5A1234, 4'hF); cycle();
      do_reset(1);
      bus_if.rsp_ready = 1'b1;
      repeat (4) cycle();
      bus_if.rd_valid = 1'b1; bus_if.rd_addr = 11'h0A0; cycle();
      drain();
      chk("rst_write_kept", 64'(last_pop), 64'(32'h5A5A1234));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Single-clock initiator for the team's dual-port SRAM macro (port 0 write-only with byte mask, port 1 read-only, inputs sampled on posedge, array access on negedge). It accepts write and read requests on valid/ready channels, drives the macro's port-0/port-1 pins from registers, and returns read data through a response FIFO with backpressure. It also resolves same-cycle read/write hazards on one address. It sits between a core-side master (CPU/LSU or DMA) and one SRAM instance; the SRAM's clk0/clk1 are tied to this block's clk at the top level.

## Interface
- ADDR_WIDTH, 11, word address width (matches macro).
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-enable width (DATA_WIDTH/8).
- RSP_DEPTH, 4, response FIFO depth and read credit limit (≥4 for full throughput).

Ports:
- clk  in  1  single clock; also drives SRAM clk0/clk1.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request ready.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  NUM_WMASKS  byte enables; bit i covers data[8i+7:8i].
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request ready.
- rd_addr  in  ADDR_WIDTH  read word address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  read response accepted.
- rsp_data  out  DATA_WIDTH  read response data.
- busy  out  1  reads outstanding (issued, not yet popped).
- sram_csb0  out  1  port-0 chip select, active low.
- sram_wmask0  out  NUM_WMASKS  port-0 write mask.
- sram_addr0  out  ADDR_WIDTH  port-0 address.
- sram_din0  out  DATA_WIDTH  port-0 write data.
- sram_csb1  out  1  port-1 chip select, active low.
- sram_addr1  out  ADDR_WIDTH  port-1 address.
- sram_dout1  in  DATA_WIDTH  port-1 read data.

## Operation
- Handshake: transfer when valid & ready at a posedge. Requesters hold payload stable while valid & !ready.
- wr_ready = !rst. There is no write backpressure.
- Write accepted with wr_mask≠0: sram_csb0←0 and sram_addr0/din0/wmask0 are registered for one cycle. Otherwise sram_csb0←1; addr/din/wmask hold their last values.
- A write accepted with wr_mask=0 is consumed with no SRAM access.
- Outstanding counter: 0..RSP_DEPTH. +1 on read accept, −1 on response pop; both in one cycle leaves it unchanged. busy = (outstanding≠0).
- rd_ready = !rst & (outstanding < RSP_DEPTH) & !hazard. Depends on registered count only; no rsp_ready→rd_ready path.
- hazard = wr_valid & (wr_mask≠0) & (wr_addr==rd_addr). The write goes first and the read stalls one cycle, so the read returns the post-write data.
- Read pipeline, 2 registered stages:
  - S1: sram_csb1←0, sram_addr1←rd_addr.
  - S2: tracks the SRAM access.
  - On S2 retire, sram_dout1 is pushed into the response FIFO unconditionally. Credits guarantee the FIFO has space.
  - sram_csb1←1 in cycles with no accept.
- Response FIFO: rsp_valid = not empty; rsp_data = head. rsp_data is stable while rsp_valid & !rsp_ready. Push and pop in the same cycle are legal, including when the FIFO is full-1 or empty.
- Responses return in request order.

## Timing
- Write accepted at edge E: SRAM samples at E+1, array updated at the following negedge. A read of the same address accepted at E+1 or later sees the new data.
- Read accepted at edge A (FIFO empty): SRAM samples at A+1; dout1 captured and rsp_valid=1 from edge A+2. Latency is 2 cycles.
- Throughput is one read/cycle sustained with rsp_ready=1 (steady-state outstanding=3 < 4). One write/cycle is supported concurrently.
- Reset, at any edge with rst=1: sram_csb0=1, sram_csb1=1, sram_addr0/addr1/din0/wmask0=0, pipeline valids=0, FIFO empty, outstanding=0, rsp_valid=0, busy=0, rsp_data=0. wr_ready=rd_ready=0 while rst is high.
- Reset mid-operation:
  - A write accepted at the edge before reset still commits, because the SRAM samples sram_csb0=0 at the reset edge.
  - All in-flight reads and FIFO contents are dropped without a response.

## Test plan
- Write then read: write addr 0x005, data 0xDEADBEEF, mask 4'hF; read 0x005 next cycle → rsp_valid 2 cycles after read accept, rsp_data=0xDEADBEEF.
- Byte mask: preload 0x005=0x11223344; write 0xAABBCCDD with mask 4'b0101 → read returns 0x11BB33DD. A wr_mask=0 write leaves sram_csb0=1 with data unchanged.
- Hazard: wr_valid & rd_valid same cycle, both address 0x07F, write data 0x0000CAFE → rd_ready=0 that cycle, read accepted next cycle, returns 0x0000CAFE.
- Backpressure: rsp_ready=0, issue reads to 0x000..0x005 back-to-back → exactly 4 accepted, then rd_ready=0 and busy=1. Release rsp_ready → 4 in-order responses with stable data while stalled; rd_ready reasserts after the first pop.
- Streaming: 16 consecutive reads with rsp_ready=1 → rd_ready never drops; responses on 16 consecutive cycles, first at accept+2.
- Reset mid-flight: 2 reads in flight plus 1 write accepted, assert rst for 1 cycle → no responses, all outputs at reset values, busy=0; the write data is present on a later read.
